// File: rtl/core_pipe_exec_gen.sv
// ============================================================================
//  Module      : core_pipe_exec_gen
//  Description : Execute stage between decode (s2) and writeback (s3).
//                Computes ALU results, resolves branches and jumps, holds
//                the s3 pipeline register under valid/ready, and raises a
//                held control-flow-change request towards fetch.
//                Optional macro CORE_EXEC_RVC_EN selects 2-byte target
//                alignment (compressed ISA); otherwise 4-byte alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_pipe_exec_gen #(
    parameter int XLEN    = 64,
    parameter int RA_W    = 5,
    parameter int CAUSE_W = 6
) (
    input  logic               g_clk,
    input  logic               g_reset,
    input  logic               s2_valid,
    output logic               s2_ready,
    input  logic [XLEN-1:0]    s2_rs1,
    input  logic [XLEN-1:0]    s2_rs2,
    input  logic [XLEN-1:0]    s2_imm,
    input  logic [XLEN-1:0]    s2_pc,
    input  logic [XLEN-1:0]    s2_npc,
    input  logic [RA_W-1:0]    s2_rd,
    input  logic [3:0]         s2_alu_op,
    input  logic               s2_alu_imm,
    input  logic               s2_alu_word,
    input  logic [3:0]         s2_cfu_op,
    input  logic               s2_trap,
    output logic               s3_valid,
    input  logic               s3_ready,
    output logic [XLEN-1:0]    s3_pc,
    output logic [RA_W-1:0]    s3_rd,
    output logic [XLEN-1:0]    s3_wdata,
    output logic               s3_trap,
    output logic               cf_valid,
    input  logic               cf_ack,
    output logic [XLEN-1:0]    cf_target,
    output logic [CAUSE_W-1:0] cf_cause
);

    localparam int c_SHW = $clog2(XLEN);

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLL  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_SLT  = 4'd8;
    localparam logic [3:0] c_ALU_SLTU = 4'd9;

    localparam logic [3:0] c_CF_BEQ  = 4'd1;
    localparam logic [3:0] c_CF_BNE  = 4'd2;
    localparam logic [3:0] c_CF_BLT  = 4'd3;
    localparam logic [3:0] c_CF_BGE  = 4'd4;
    localparam logic [3:0] c_CF_BLTU = 4'd5;
    localparam logic [3:0] c_CF_BGEU = 4'd6;
    localparam logic [3:0] c_CF_JAL  = 4'd7;
    localparam logic [3:0] c_CF_JALR = 4'd8;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_REQ  = 1'b1;

    logic [0:0]         r_state;
    logic               r_s3_valid;
    logic [XLEN-1:0]    r_s3_pc;
    logic [RA_W-1:0]    r_s3_rd;
    logic [XLEN-1:0]    r_s3_wdata;
    logic               r_s3_trap;
    logic [XLEN-1:0]    r_cf_target;
    logic [CAUSE_W-1:0] r_cf_cause;

    logic               w_s2_ready;
    logic               w_s2_fire;
    logic [XLEN-1:0]    w_lhs;
    logic [XLEN-1:0]    w_rhs;
    logic [c_SHW-1:0]   w_shamt;
    logic [XLEN-1:0]    w_alu_full;
    logic [XLEN-1:0]    w_alu;
    logic               w_taken;
    logic               w_is_branch;
    logic               w_is_jump;
    logic [XLEN-1:0]    w_target;
    logic               w_misal;
    logic               w_cf_req;
    logic               w_bad_tgt;

    // New work is refused while s3 cannot drain or a redirect is outstanding
    assign w_s2_ready = (!r_s3_valid | s3_ready) & (r_state == c_ST_IDLE);
    assign w_s2_fire  = s2_valid & w_s2_ready;

    assign w_lhs   = s2_rs1;
    assign w_rhs   = s2_alu_imm ? s2_imm : s2_rs2;
    assign w_shamt = w_rhs[c_SHW-1:0];

    // Full-width ALU
    always_comb begin
        w_alu_full = '0;
        case (s2_alu_op)
            c_ALU_ADD:  w_alu_full = w_lhs + w_rhs;
            c_ALU_SUB:  w_alu_full = w_lhs - w_rhs;
            c_ALU_AND:  w_alu_full = w_lhs & w_rhs;
            c_ALU_OR:   w_alu_full = w_lhs | w_rhs;
            c_ALU_XOR:  w_alu_full = w_lhs ^ w_rhs;
            c_ALU_SLL:  w_alu_full = w_lhs << w_shamt;
            c_ALU_SRL:  w_alu_full = w_lhs >> w_shamt;
            c_ALU_SRA:  w_alu_full = $signed(w_lhs) >>> w_shamt;
            c_ALU_SLT:  w_alu_full = {{(XLEN-1){1'b0}}, ($signed(w_lhs) < $signed(w_rhs))};
            c_ALU_SLTU: w_alu_full = {{(XLEN-1){1'b0}}, (w_lhs < w_rhs)};
            default:    w_alu_full = '0;
        endcase
    end

    // 32-bit word ops exist only on the 64-bit datapath
    generate
        if (XLEN == 64) begin : g_word64
            logic [31:0] w_l32;
            logic [31:0] w_r32;
            logic [4:0]  w_sh32;
            logic [31:0] w_res32;

            assign w_l32  = w_lhs[31:0];
            assign w_r32  = w_rhs[31:0];
            assign w_sh32 = w_rhs[4:0];

            // Word ALU, result later sign-extended from bit 31
            always_comb begin
                w_res32 = '0;
                case (s2_alu_op)
                    c_ALU_ADD:  w_res32 = w_l32 + w_r32;
                    c_ALU_SUB:  w_res32 = w_l32 - w_r32;
                    c_ALU_AND:  w_res32 = w_l32 & w_r32;
                    c_ALU_OR:   w_res32 = w_l32 | w_r32;
                    c_ALU_XOR:  w_res32 = w_l32 ^ w_r32;
                    c_ALU_SLL:  w_res32 = w_l32 << w_sh32;
                    c_ALU_SRL:  w_res32 = w_l32 >> w_sh32;
                    c_ALU_SRA:  w_res32 = $signed(w_l32) >>> w_sh32;
                    c_ALU_SLT:  w_res32 = {31'd0, ($signed(w_l32) < $signed(w_r32))};
                    c_ALU_SLTU: w_res32 = {31'd0, (w_l32 < w_r32)};
                    default:    w_res32 = '0;
                endcase
            end

            assign w_alu = s2_alu_word ? {{(XLEN-32){w_res32[31]}}, w_res32} : w_alu_full;
        end else begin : g_word32
            assign w_alu = w_alu_full;
        end
    endgenerate

    // Branch condition resolution
    always_comb begin
        w_taken = 1'b0;
        case (s2_cfu_op)
            c_CF_BEQ:  w_taken = (s2_rs1 == s2_rs2);
            c_CF_BNE:  w_taken = (s2_rs1 != s2_rs2);
            c_CF_BLT:  w_taken = ($signed(s2_rs1) <  $signed(s2_rs2));
            c_CF_BGE:  w_taken = ($signed(s2_rs1) >= $signed(s2_rs2));
            c_CF_BLTU: w_taken = (s2_rs1 <  s2_rs2);
            c_CF_BGEU: w_taken = (s2_rs1 >= s2_rs2);
            c_CF_JAL:  w_taken = 1'b1;
            c_CF_JALR: w_taken = 1'b1;
            default:   w_taken = 1'b0;
        endcase
    end

    assign w_is_branch = (s2_cfu_op >= c_CF_BEQ) && (s2_cfu_op <= c_CF_BGEU);
    assign w_is_jump   = (s2_cfu_op == c_CF_JAL) || (s2_cfu_op == c_CF_JALR);
    assign w_target    = (s2_cfu_op == c_CF_JALR)
                       ? ((s2_rs1 + s2_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                       : (s2_pc + s2_imm);

`ifdef CORE_EXEC_RVC_EN
    assign w_misal = w_target[0];
`else
    assign w_misal = |w_target[1:0];
`endif

    // An upstream trap suppresses the redirect; a bad target still redirects
    // (fetch routes it to the trap vector) but marks the instruction trapped
    assign w_cf_req  = w_taken & !s2_trap;
    assign w_bad_tgt = w_cf_req & w_misal;

    // s3 pipeline register: refill on accept, hold while writeback stalls
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_s3_valid <= 1'b0;
            r_s3_pc    <= '0;
            r_s3_rd    <= '0;
            r_s3_wdata <= '0;
            r_s3_trap  <= 1'b0;
        end else begin
            r_s3_valid <= w_s2_fire | (r_s3_valid & !s3_ready);
            if (w_s2_fire) begin
                r_s3_pc    <= s2_pc;
                r_s3_rd    <= (s2_trap | w_bad_tgt | w_is_branch) ? '0 : s2_rd;
                r_s3_wdata <= w_is_jump ? s2_npc : w_alu;
                r_s3_trap  <= s2_trap | w_bad_tgt;
            end
        end
    end

    // Redirect FSM: request captured on accept and held stable until acked
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state     <= c_ST_IDLE;
            r_cf_target <= '0;
            r_cf_cause  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_s2_fire && w_cf_req) begin
                        r_state     <= c_ST_REQ;
                        r_cf_target <= w_target;
                        r_cf_cause  <= {{(CAUSE_W-1){1'b0}}, w_misal};
                    end
                end
                c_ST_REQ: begin
                    if (cf_ack) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign s2_ready  = w_s2_ready;
    assign s3_valid  = r_s3_valid;
    assign s3_pc     = r_s3_pc;
    assign s3_rd     = r_s3_rd;
    assign s3_wdata  = r_s3_wdata;
    assign s3_trap   = r_s3_trap;
    assign cf_valid  = (r_state == c_ST_REQ);
    assign cf_target = r_cf_target;
    assign cf_cause  = r_cf_cause;

endmodule

`default_nettype wire
